// File: rtl/wf_rr_index_encoder_pkg.sv
// wf_rr_index_encoder_pkg: shared wavefront constants, encoder state encoding and helpers
package wf_rr_index_encoder_pkg;
  localparam int NUM_WF = 40;
  localparam int WF_ID_W = 6;
  typedef logic [NUM_WF-1:0] wf_vec_t;
  typedef logic [WF_ID_W-1:0] wf_id_t;
  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} enc_state_t;
  function automatic wf_vec_t wf_onehot(input wf_id_t id);
    return wf_vec_t'(1) << id;
  endfunction
  function automatic wf_id_t wf_next_ptr(input wf_id_t id);
    return (id == wf_id_t'(NUM_WF - 1)) ? '0 : id + wf_id_t'(1);
  endfunction
endpackage

// File: rtl/wf_priority_encoder.sv
// wf_priority_encoder: combinational lowest-index-first encoder with found flag
module wf_priority_encoder
  import wf_rr_index_encoder_pkg::*;
#(
  parameter int N = NUM_WF,
  parameter int W = WF_ID_W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);
  // scan from the top down so the lowest set bit is the last assignment to win
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wf_rr_index_encoder.sv
// wf_rr_index_encoder: round-robin 40->6 wavefront request encoder with registered valid/ready grant
module wf_rr_index_encoder
  import wf_rr_index_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_WF-1:0]   req,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WF_ID_W-1:0]  out_id,
  output logic [NUM_WF-1:0]   out_onehot
);
  enc_state_t state;
  wf_id_t ptr;
  wf_id_t next_ptr;
  wf_id_t search_ptr;
  wf_vec_t mask_ge_ptr;
  wf_id_t masked_id;
  wf_id_t raw_id;
  wf_id_t sel_id;
  logic masked_found;
  logic raw_found;
  // while holding, the search must already use the pointer the handshake is about to install
  assign next_ptr = wf_next_ptr(out_id);
  assign search_ptr = (state == ST_HOLD) ? next_ptr : ptr;
  for (genvar g = 0; g < NUM_WF; g++) begin : g_mask
    assign mask_ge_ptr[g] = wf_id_t'(g) >= search_ptr;
  end
  wf_priority_encoder u_masked (
    .vec   (req & mask_ge_ptr),
    .idx   (masked_id),
    .found (masked_found)
  );
  wf_priority_encoder u_raw (
    .vec   (req),
    .idx   (raw_id),
    .found (raw_found)
  );
  assign sel_id = masked_found ? masked_id : raw_id;
  assign out_valid = (state == ST_HOLD);
  // grant FSM: load on any request when empty, advance pointer and reload only on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      ptr <= '0;
      out_id <= '0;
      out_onehot <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (raw_found) begin
            state <= ST_HOLD;
            out_id <= sel_id;
            out_onehot <= wf_onehot(sel_id);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            ptr <= next_ptr;
            if (raw_found) begin
              out_id <= sel_id;
              out_onehot <= wf_onehot(sel_id);
            end else begin
              state <= ST_EMPTY;
              out_onehot <= '0;
            end
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_wf_rr_index_encoder.sv
// tb_wf_rr_index_encoder: scoreboard bench with a rotating-search reference model
module tb_wf_rr_index_encoder;
  import wf_rr_index_encoder_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_WF-1:0] req = '0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [WF_ID_W-1:0] out_id;
  logic [NUM_WF-1:0] out_onehot;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic v;
    logic id_known;
    int id;
  } exp_t;
  exp_t exp_q[$];
  logic m_valid = 1'b0;
  logic m_known = 1'b1;
  int m_id = 0;
  int m_ptr = 0;
  wf_rr_index_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_onehot (out_onehot)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int rr_search(input logic [NUM_WF-1:0] r, input int p);
    for (int k = 0; k < NUM_WF; k++)
      if (r[(p + k) % NUM_WF]) return (p + k) % NUM_WF;
    return -1;
  endfunction
  // reference model: steps on each rising edge and queues the expected output state
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_known = 1'b1;
        m_id = 0;
        m_ptr = 0;
      end else if (!m_valid) begin
        if (req != '0) begin
          m_id = rr_search(req, m_ptr);
          m_valid = 1'b1;
          m_known = 1'b1;
        end
      end else if (out_ready) begin
        m_ptr = (m_id + 1) % NUM_WF;
        if (req != '0) m_id = rr_search(req, m_ptr);
        else begin
          m_valid = 1'b0;
          m_known = 1'b0;
        end
      end
      exp_q.push_back('{v: m_valid, id_known: m_known, id: m_id});
    end
  end
  // monitor: compares the DUT against the queued expectation shortly after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_valid", 64'(out_valid), 64'(e.v));
        if (e.id_known) check("out_id", 64'(out_id), 64'(e.id));
        check("out_onehot", 64'(out_onehot), e.v ? (64'd1 << e.id) : 64'd0);
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic drive(input logic [NUM_WF-1:0] r, input logic rdy, input int n);
    req = r;
    out_ready = rdy;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic [NUM_WF-1:0] all_ones;
    logic [NUM_WF-1:0] r;
    all_ones = '1;
    @(negedge clk);
    drive(all_ones, 1'b1, 3);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_onehot", 64'(out_onehot), 64'd0);
    rst_n = 1'b1;
    drive(NUM_WF'(1) << 17, 1'b1, 1);
    drive('0, 1'b1, 3);
    do_reset();
    drive(all_ones, 1'b1, 45);
    do_reset();
    drive(NUM_WF'(1) << 30, 1'b0, 1);
    drive((NUM_WF'(1) << 30) | (NUM_WF'(1) << 5), 1'b1, 4);
    do_reset();
    drive(NUM_WF'(1) << 9, 1'b0, 1);
    drive(NUM_WF'(1) << 20, 1'b0, 3);
    drive(NUM_WF'(1) << 20, 1'b1, 1);
    drive('0, 1'b1, 2);
    do_reset();
    drive(NUM_WF'(1) << 33, 1'b0, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_id", 64'(out_id), 64'd0);
    check("async_onehot", 64'(out_onehot), 64'd0);
    @(negedge clk);
    req = all_ones;
    @(negedge clk);
    rst_n = 1'b1;
    drive(all_ones, 1'b1, 3);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = NUM_WF'(1) << $urandom_range(0, NUM_WF - 1);
        2: r = (NUM_WF'(1) << $urandom_range(0, NUM_WF - 1)) | (NUM_WF'(1) << $urandom_range(0, NUM_WF - 1));
        default: r = NUM_WF'({$urandom, $urandom});
      endcase
      drive(r, ($urandom_range(0, 3) != 0), 1);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
